la_capture_ctrl: RTL and testbench
==================================

Name: la_capture_ctrl

Overview:
- Parametrised logic-analyzer capture sequencer; successor to the single-counter start/done sample logic in the top-level register block.
- Adds a programmable sample-rate divider, mask/pattern trigger, and separate pre-trigger and post-trigger sample counts.
- Generalised to any LA channel width.
- Sits between the memory-controller register file (config in, status out) and the SRAM clock gating / SIO capture path.

Parameters:
- LA_WIDTH, 8, sampled channel width.
- COUNT_WIDTH, 23, width of sample counters and of the pre/post counts.
- DIV_WIDTH, 8, width of the sample-clock divider.

Ports:
- clock  in  1  single system clock; all logic on its posedge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; arms a capture.
- abort  in  1  one-cycle pulse; cancels a capture.
- clk_div  in  DIV_WIDTH  sample period = clk_div+1 clocks.
- samples_pre  in  COUNT_WIDTH  samples to take before trigger is evaluated.
- samples_post  in  COUNT_WIDTH  samples to take after trigger.
- trig_mask  in  LA_WIDTH  1 = channel participates in trigger.
- trig_pattern  in  LA_WIDTH  required level per masked channel.
- sample_in  in  LA_WIDTH  synchronised LA inputs.
- sample_strobe  out  1  one-cycle pulse per sample; drives SRAM clock gating.
- busy  out  1  high in ARM, WAIT_TRIG and POST.
- triggered  out  1  trigger seen this capture.
- done  out  1  capture complete; sticky.
- sample_count  out  COUNT_WIDTH  samples taken this capture; wraps modulo 2^COUNT_WIDTH.
- trig_index  out  COUNT_WIDTH  sample_count value at the trigger sample.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE; all outputs 0; divider counter 0.
- FSM states:
  - IDLE: start -> ARM.
  - ARM: counts samples_pre strobes, then -> WAIT_TRIG. samples_pre=0 -> WAIT_TRIG on the cycle after start.
  - WAIT_TRIG: at each strobe, the trigger hits if (sample_in & trig_mask) == (trig_pattern & trig_mask). On a hit: triggered<=1, trig_index<=sample_count (pre-increment), -> POST.
  - POST: counts samples_post strobes after the trigger sample, then -> DONE. samples_post=0 -> DONE on the trigger strobe.
  - DONE: busy=0, done=1. start -> ARM.
- Divider:
  - Free-runs only while busy.
  - Clears on entry to ARM.
  - sample_strobe asserts when the divider equals clk_div, then the divider clears.
  - clk_div=0 -> strobe every clock while busy.
  - First strobe occurs clk_div+1 clocks after the start edge.
- Counting: sample_count increments on every strobe in ARM, WAIT_TRIG and POST. The trigger sample counts as a sample.
- start (from IDLE or DONE):
  - Clears done, triggered, sample_count and trig_index.
  - Latches clk_div, samples_pre, samples_post, trig_mask and trig_pattern into shadow registers. Later changes to these inputs do not affect the capture in progress.
- start while busy: ignored.
- abort in any state: -> IDLE next cycle; busy, done and triggered all 0; sample_count and trig_index hold.
- start and abort in the same cycle: abort wins.
- trig_mask=0: trigger on the first WAIT_TRIG strobe.
- Counter limits: comparisons are equality against the latched count, so a count of 2^COUNT_WIDTH-1 is legal.
- Reset mid-capture: identical to reset from IDLE.

Optional Feature:
- Macro: LA_EDGE_TRIG_EN.
- Defined:
  - Adds input trig_edge [LA_WIDTH], latched at start.
  - For channels with trig_edge=1, the trigger also requires a transition to trig_pattern since the previous strobe's sample.
  - Previous-sample register is loaded at every strobe.
  - The first WAIT_TRIG strobe after ARM compares against the last ARM sample. With samples_pre=0 the first WAIT_TRIG strobe never edge-matches.
- Undefined: port absent; trigger is level-only, as above.

Decomposition:
- Shared package la_pkg: FSM state encoding (IDLE, ARM, WAIT_TRIG, POST, DONE) and default LA_WIDTH/COUNT_WIDTH constants. The register map later references these.
- Sub-module la_clk_div: DIV_WIDTH divider with enable, sync clear and strobe output; reusable for the PWM/frequency work.

Test Plan:
- Basic capture: clk_div=0, pre=4, post=3, mask=0x01, pattern=0x01; sample_in bit0 rises at strobe 10 -> 4 ARM strobes, trig_index=9, done after sample_count=13; busy falls with done the same cycle.
- Divider: clk_div=3, pre=0, post=2, mask=0 -> strobes every 4 clocks starting 4 clocks after start; trig_index=0; done at sample_count=3.
- Abort and start/abort priority: abort during POST -> IDLE next cycle, done=0, sample_count held; start+abort in the same cycle from IDLE -> stays IDLE.
- Config shadowing: change samples_post from 5 to 1 mid-ARM -> capture still takes 5 post samples; start asserted while busy has no effect.
- Reset: reset_n low for 1 cycle during WAIT_TRIG -> all outputs 0 next cycle; a new start behaves as from power-up.
- LA_EDGE_TRIG_EN: mask=0x01, pattern=0x01, edge=0x01, bit0 held high through ARM -> no trigger until bit0 goes low then high; trig_index equals the strobe of the rising edge.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM encoding and default widths.
package la_pkg;

  localparam int unsigned LA_WIDTH_DEF    = 8;
  localparam int unsigned COUNT_WIDTH_DEF = 23;
  localparam int unsigned DIV_WIDTH_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARM       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_DONE      = 3'd4
  } la_state_t;

endpackage

// File: rtl/la_clk_div.sv
// Programmable clock divider: strobe every (period+1) enabled clocks.
// Synchronous clear restarts the count; the counter holds while disabled.
module la_clk_div #(
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 strobe
);

  logic [DIV_WIDTH-1:0] cnt;

  assign strobe = enable && (cnt == period);

  // Divider counter: clears on strobe so the period is period+1 clocks
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= strobe ? '0 : cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/la_capture_ctrl.sv
// Logic-analyzer capture sequencer: sample-rate divider, mask/pattern
// trigger, pre- and post-trigger sample counts.
// Optional: LA_EDGE_TRIG_EN adds per-channel edge qualification (trig_edge).
module la_capture_ctrl
  import la_pkg::*;
#(
  parameter int unsigned LA_WIDTH    = LA_WIDTH_DEF,
  parameter int unsigned COUNT_WIDTH = COUNT_WIDTH_DEF,
  parameter int unsigned DIV_WIDTH   = DIV_WIDTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DIV_WIDTH-1:0]   clk_div,
  input  logic [COUNT_WIDTH-1:0] samples_pre,
  input  logic [COUNT_WIDTH-1:0] samples_post,
  input  logic [LA_WIDTH-1:0]    trig_mask,
  input  logic [LA_WIDTH-1:0]    trig_pattern,
  input  logic [LA_WIDTH-1:0]    sample_in,
`ifdef LA_EDGE_TRIG_EN
  input  logic [LA_WIDTH-1:0]    trig_edge,
`endif
  output logic                   sample_strobe,
  output logic                   busy,
  output logic                   triggered,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] sample_count,
  output logic [COUNT_WIDTH-1:0] trig_index
);

  la_state_t state, state_next;

  logic                   start_ok;
  logic                   trig_evt;
  logic                   trig_hit;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic [COUNT_WIDTH-1:0] post_taken;

  // Configuration shadows, captured when a capture is armed
  logic [DIV_WIDTH-1:0]   div_sh;
  logic [COUNT_WIDTH-1:0] pre_sh;
  logic [COUNT_WIDTH-1:0] post_sh;
  logic [LA_WIDTH-1:0]    mask_sh;
  logic [LA_WIDTH-1:0]    pattern_sh;
`ifdef LA_EDGE_TRIG_EN
  logic [LA_WIDTH-1:0]    edge_sh;
  logic [LA_WIDTH-1:0]    prev_sample;
  logic                   prev_valid;
  logic [LA_WIDTH-1:0]    edge_bits;
`endif

  assign busy      = (state == ST_ARM) || (state == ST_WAIT_TRIG) || (state == ST_POST);
  assign done      = (state == ST_DONE);
  assign count_inc = sample_count + COUNT_WIDTH'(1);
  // Post samples taken including the current strobe; modular, so it stays
  // correct across a sample_count wrap.
  assign post_taken = sample_count - trig_index;

  la_clk_div #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_div (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (busy),
    .clear   (start_ok),
    .period  (div_sh),
    .strobe  (sample_strobe)
  );

  // Trigger qualification: masked level match, optionally with edge bits
  always_comb begin
`ifdef LA_EDGE_TRIG_EN
    edge_bits = edge_sh & mask_sh;
    trig_hit  = (((sample_in ^ pattern_sh) & mask_sh) == '0) &&
                ((edge_bits == '0) ||
                 (prev_valid && (((sample_in ^ prev_sample) & edge_bits) == edge_bits)));
`else
    trig_hit  = (((sample_in ^ pattern_sh) & mask_sh) == '0);
`endif
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; abort overrides everything, including start
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    trig_evt   = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = (samples_pre == '0) ? ST_WAIT_TRIG : ST_ARM;
        end
      end
      ST_ARM: begin
        if (sample_strobe && (count_inc == pre_sh)) state_next = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (sample_strobe && trig_hit) begin
          trig_evt   = 1'b1;
          state_next = (post_sh == '0) ? ST_DONE : ST_POST;
        end
      end
      ST_POST: begin
        if (sample_strobe && (post_taken == post_sh)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort) begin
      state_next = ST_IDLE;
      start_ok   = 1'b0;
      trig_evt   = 1'b0;
    end
  end

  // Capture data: counters, trigger record and configuration shadows
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      triggered    <= 1'b0;
      sample_count <= '0;
      trig_index   <= '0;
      div_sh       <= '0;
      pre_sh       <= '0;
      post_sh      <= '0;
      mask_sh      <= '0;
      pattern_sh   <= '0;
`ifdef LA_EDGE_TRIG_EN
      edge_sh      <= '0;
      prev_sample  <= '0;
      prev_valid   <= 1'b0;
`endif
    end else if (abort) begin
      triggered <= 1'b0;
    end else if (start_ok) begin
      triggered    <= 1'b0;
      sample_count <= '0;
      trig_index   <= '0;
      div_sh       <= clk_div;
      pre_sh       <= samples_pre;
      post_sh      <= samples_post;
      mask_sh      <= trig_mask;
      pattern_sh   <= trig_pattern;
`ifdef LA_EDGE_TRIG_EN
      edge_sh      <= trig_edge;
      prev_valid   <= 1'b0;
`endif
    end else begin
      if (sample_strobe) begin
        sample_count <= count_inc;
`ifdef LA_EDGE_TRIG_EN
        prev_sample  <= sample_in;
        prev_valid   <= 1'b1;
`endif
      end
      if (trig_evt) begin
        triggered  <= 1'b1;
        trig_index <= sample_count;
      end
    end
  end

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Bench for la_capture_ctrl: directed captures; a monitor compares the
// completion record at each rising done against a queue of expectations.
module tb_la_capture_ctrl;

  localparam int unsigned LW = 8;
  localparam int unsigned CW = 23;
  localparam int unsigned DW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] clk_div = '0;
  logic [CW-1:0] samples_pre = '0;
  logic [CW-1:0] samples_post = '0;
  logic [LW-1:0] trig_mask = '0;
  logic [LW-1:0] trig_pattern = '0;
  logic [LW-1:0] sample_in = '0;
`ifdef LA_EDGE_TRIG_EN
  logic [LW-1:0] trig_edge = '0;
`endif
  logic          sample_strobe;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [CW-1:0] sample_count;
  logic [CW-1:0] trig_index;

  la_capture_ctrl #(.LA_WIDTH(LW), .COUNT_WIDTH(CW), .DIV_WIDTH(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .abort         (abort),
    .clk_div       (clk_div),
    .samples_pre   (samples_pre),
    .samples_post  (samples_post),
    .trig_mask     (trig_mask),
    .trig_pattern  (trig_pattern),
    .sample_in     (sample_in),
`ifdef LA_EDGE_TRIG_EN
    .trig_edge     (trig_edge),
`endif
    .sample_strobe (sample_strobe),
    .busy          (busy),
    .triggered     (triggered),
    .done          (done),
    .sample_count  (sample_count),
    .trig_index    (trig_index)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned count;
    int unsigned tidx;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned strobe_cnt = 0;
  int unsigned base = 0;
  logic        done_q = 1'b0;
  logic        busy_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clock) if (sample_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  // Completion monitor
  always @(negedge clock) begin
    if (done === 1'b1 && done_q !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1, expected no completion (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_sample_count", 32'(sample_count), mon_e.count);
        check("done_trig_index", 32'(trig_index), mon_e.tidx);
        check("done_triggered", 32'(triggered), 1);
        check("done_busy_low", 32'(busy), 0);
        check("busy_before_done", 32'(busy_q), 1);
      end
    end
    done_q = done;
    busy_q = busy;
  end

  task automatic pulse_start();
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    base = strobe_cnt;
  endtask

  task automatic wait_strobes(input int unsigned target);
    for (int i = 0; i < 4000; i++) begin
      if (strobe_cnt - base >= target) return;
      @(posedge clock); #1;
    end
    check("strobe_timeout", strobe_cnt - base, target);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 4000; i++) begin
      if (done === 1'b1) return;
      @(posedge clock); #1;
    end
    check("done_timeout", 32'(done), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_triggered"}, 32'(triggered), 0);
    check({tag, "_strobe"}, 32'(sample_strobe), 0);
    check({tag, "_sample_count"}, 32'(sample_count), 0);
    check({tag, "_trig_index"}, 32'(trig_index), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Power-up reset
    repeat (3) @(posedge clock);
    #1 check_all_zero("reset");
    reset_n = 1'b1;

    // Basic capture: bit0 high through ARM, low, then rises at strobe 10
    clk_div = 8'd0; samples_pre = 23'd4; samples_post = 23'd3;
    trig_mask = 8'h01; trig_pattern = 8'h01; sample_in = 8'h01;
    exp_q.push_back('{count: 13, tidx: 9});
    pulse_start();
    wait_strobes(4);
    sample_in = 8'h00;
    wait_strobes(9);
    check("basic_count_pre_trig", 32'(sample_count), 9);
    check("basic_not_triggered", 32'(triggered), 0);
    sample_in = 8'h01;
    wait_done();
    sample_in = 8'h00;

    // Divider: period 4, pre=0, mask=0 triggers on first strobe
    clk_div = 8'd3; samples_pre = 23'd0; samples_post = 23'd2; trig_mask = 8'h00;
    exp_q.push_back('{count: 3, tidx: 0});
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      check($sformatf("div_strobe_c%0d", c), 32'(sample_strobe), ((c % 4) == 0) ? 1 : 0);
    end
    wait_done();

    // Abort during POST: pre=2, trigger on strobe 3, abort after 5 strobes
    clk_div = 8'd0; samples_pre = 23'd2; samples_post = 23'd5; trig_mask = 8'h00;
    pulse_start();
    wait_strobes(5);
    check("abort_pre_count", 32'(sample_count), 5);
    abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_triggered", 32'(triggered), 0);
    check("abort_count_held", 32'(sample_count), 5);
    check("abort_tidx_held", 32'(trig_index), 2);
    // start and abort together from IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1 start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 0);
    check("start_abort_count", 32'(sample_count), 5);
    @(posedge clock); #1;
    check("start_abort_idle", 32'(busy), 0);

    // Config shadowing and start while busy
    clk_div = 8'd1; samples_pre = 23'd3; samples_post = 23'd5;
    trig_mask = 8'h80; trig_pattern = 8'h80; sample_in = 8'h80;
    exp_q.push_back('{count: 9, tidx: 3});
    pulse_start();
    @(posedge clock); #1;
    samples_post = 23'd1; clk_div = 8'd0; trig_mask = 8'h00;
    start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    check("busy_start_ignored", 32'(busy), 1);
    wait_done();
    sample_in = 8'h00;

    // Reset during WAIT_TRIG, then a fresh capture
    clk_div = 8'd0; samples_pre = 23'd2; samples_post = 23'd3;
    trig_mask = 8'h01; trig_pattern = 8'h01; sample_in = 8'h00;
    pulse_start();
    wait_strobes(4);
    reset_n = 1'b0;
    @(posedge clock); #1 reset_n = 1'b1;
    check_all_zero("midreset");
    samples_pre = 23'd1; samples_post = 23'd1; trig_mask = 8'h00;
    exp_q.push_back('{count: 3, tidx: 1});
    pulse_start();
    wait_done();

`ifdef LA_EDGE_TRIG_EN
    // Edge trigger: bit0 high through ARM must not trigger without a new rise
    clk_div = 8'd0; samples_pre = 23'd3; samples_post = 23'd1;
    trig_mask = 8'h01; trig_pattern = 8'h01; trig_edge = 8'h01; sample_in = 8'h01;
    exp_q.push_back('{count: 9, tidx: 7});
    pulse_start();
    wait_strobes(5);
    check("edge_no_level_trig", 32'(triggered), 0);
    sample_in = 8'h00;
    wait_strobes(7);
    sample_in = 8'h01;
    wait_done();
    trig_edge = 8'h00;
`endif

    repeat (2) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
